// File: rtl/paddle_engine_pkg.sv
// Shared pong video definitions: raster counter widths, playfield height, colour format.
package paddle_engine_pkg;
  localparam int unsigned H_W          = 11;
  localparam int unsigned V_W          = 10;
  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned COLOR_W      = 8;
  localparam logic [COLOR_W-1:0] BLACK = 8'h00;
endpackage

// File: rtl/paddle_engine_if.sv
// Raster/button inputs and paddle position/pixel outputs of the paddle engine.
interface paddle_engine_if
  import paddle_engine_pkg::*;
#(
  parameter int unsigned N_PADDLES = 2
);
  logic [H_W*N_PADDLES-1:0] x_pos;
  logic [N_PADDLES-1:0]     btn_up;
  logic [N_PADDLES-1:0]     btn_down;
  logic [H_W-1:0]           hcount;
  logic [V_W-1:0]           vcount;
  logic [V_W*N_PADDLES-1:0] y_pos;
  logic [COLOR_W-1:0]       pixel;

  modport master (output x_pos, btn_up, btn_down, hcount, vcount, input y_pos, pixel);
  modport slave  (input x_pos, btn_up, btn_down, hcount, vcount, output y_pos, pixel);
endinterface

// File: rtl/paddle_engine_pos.sv
// One paddle's vertical position: tick-gated move with exact clamp to 0..V_ACTIVE-HEIGHT.
module paddle_pos
  import paddle_engine_pkg::*;
#(
  parameter int unsigned HEIGHT   = 128,
  parameter int unsigned SPEED    = 4,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           up,
  input  logic           down,
  output logic [V_W-1:0] y
);
  localparam int unsigned Y_MAX  = V_ACTIVE - HEIGHT;
  localparam int unsigned Y_INIT = Y_MAX / 2;
  localparam int unsigned AW     = 12;

  logic [AW-1:0] y_ext, y_sum, y_up, y_dn;

  // Widened arithmetic so neither direction can wrap before the clamp.
  always_comb begin
    y_ext = AW'(y);
    y_sum = y_ext + AW'(SPEED);
    y_up  = (y_ext >= AW'(SPEED)) ? y_ext - AW'(SPEED) : '0;
    y_dn  = (y_sum >= AW'(Y_MAX)) ? AW'(Y_MAX) : y_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y <= V_W'(Y_INIT);
    end else if (tick && up && !down) begin
      y <= V_W'(y_up);
    end else if (tick && down && !up) begin
      y <= V_W'(y_dn);
    end
  end
endmodule

// File: rtl/paddle_engine.sv
// Paddle renderer: per-channel position registers plus hit test and priority pixel mux.
// Optional build macro PADDLE_BORDER_EN draws a 1-pixel BORDER_COLOR outline on each paddle.
module paddle_engine
  import paddle_engine_pkg::*;
#(
  parameter int unsigned N_PADDLES  = 2,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned HEIGHT     = 128,
  parameter int unsigned SPEED      = 4,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned FRAME_LINE = 600,
  parameter logic [N_PADDLES*COLOR_W-1:0] COLORS = 16'hBBBB,
  parameter logic [COLOR_W-1:0] BORDER_COLOR     = 8'hFF
) (
  input logic             clk,
  input logic             reset,
  paddle_engine_if.slave  ifc
);
`ifdef PADDLE_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif
  localparam int unsigned CW = 12;

  logic                 frame_tick;
  logic [V_W-1:0]       y_arr [N_PADDLES];
  logic [N_PADDLES-1:0] hit;
  logic [N_PADDLES-1:0] ring;
  logic [COLOR_W-1:0]   pixel_next;

  assign frame_tick = (ifc.hcount == '0) && (ifc.vcount == V_W'(FRAME_LINE));

  for (genvar i = 0; i < N_PADDLES; i++) begin : g_ch
    logic [CW-1:0] hx, vy, xl, xr, yt, yb;

    paddle_pos #(
      .HEIGHT   (HEIGHT),
      .SPEED    (SPEED),
      .V_ACTIVE (V_ACTIVE)
    ) u_pos (
      .clk   (clk),
      .reset (reset),
      .tick  (frame_tick),
      .up    (ifc.btn_up[i]),
      .down  (ifc.btn_down[i]),
      .y     (y_arr[i])
    );

    // 12-bit bounds so a paddle near column 2047 does not wrap its right edge.
    assign hx = CW'(ifc.hcount);
    assign vy = CW'(ifc.vcount);
    assign xl = CW'(ifc.x_pos[H_W*i +: H_W]);
    assign xr = xl + CW'(WIDTH);
    assign yt = CW'(y_arr[i]);
    assign yb = yt + CW'(HEIGHT);

    assign hit[i]  = (hx >= xl) && (hx < xr) && (vy >= yt) && (vy < yb);
    assign ring[i] = (hx == xl) || (hx == xr - CW'(1)) || (vy == yt) || (vy == yb - CW'(1));
  end

  always_comb begin
    ifc.y_pos = '0;
    for (int i = 0; i < N_PADDLES; i++) begin
      ifc.y_pos[V_W*i +: V_W] = y_arr[i];
    end
  end

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    pixel_next = BLACK;
    for (int i = N_PADDLES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pixel_next = (BORDER_EN && ring[i]) ? BORDER_COLOR : COLORS[COLOR_W*i +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifc.pixel <= BLACK;
    end else begin
      ifc.pixel <= pixel_next;
    end
  end
endmodule

// File: tb/tb_paddle_engine.sv
// Bench for paddle_engine: two instances (default and 16'h1CE0 colours) against a rule-level model.
module tb_paddle_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] x_pos;
  logic [1:0]  up, dn;
  logic [10:0] hc;
  logic [9:0]  vc;
  bit          chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          my [2];
  int          ea, eb;

`ifdef PADDLE_BORDER_EN
  localparam logic [7:0] RING_A = 8'hFF;
  localparam logic [7:0] RING_B = 8'hFF;
`else
  localparam logic [7:0] RING_A = 8'hBB;
  localparam logic [7:0] RING_B = 8'hE0;
`endif

  paddle_engine_if #(.N_PADDLES(2)) ifa ();
  paddle_engine_if #(.N_PADDLES(2)) ifb ();

  assign ifa.x_pos = x_pos;  assign ifb.x_pos = x_pos;
  assign ifa.btn_up = up;    assign ifb.btn_up = up;
  assign ifa.btn_down = dn;  assign ifb.btn_down = dn;
  assign ifa.hcount = hc;    assign ifb.hcount = hc;
  assign ifa.vcount = vc;    assign ifb.vcount = vc;

  paddle_engine dut_a (.clk(clk), .reset(reset), .ifc(ifa));
  paddle_engine #(.COLORS(16'h1CE0)) dut_b (.clk(clk), .reset(reset), .ifc(ifb));

  always #5 clk = ~clk;

  // Colour of the first paddle (lowest index) covering raster point (h,v), 0 if none.
  function automatic int calc(int h, int v, int x0, int x1, int y0, int y1, logic [15:0] col);
    int xs [2];
    int ys [2];
    xs[0] = x0; xs[1] = x1; ys[0] = y0; ys[1] = y1;
    for (int c = 0; c < 2; c++) begin
      if (h >= xs[c] && h < xs[c] + 16 && v >= ys[c] && v < ys[c] + 128) begin
`ifdef PADDLE_BORDER_EN
        if (h == xs[c] || h == xs[c] + 15 || v == ys[c] || v == ys[c] + 127) return 32'hFF;
`endif
        return int'(col >> (8 * c)) & 32'hFF;
      end
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      my[0] = 236; my[1] = 236; ea = 0; eb = 0;
    end else begin
      ea = calc(hc, vc, x_pos[10:0], x_pos[21:11], my[0], my[1], 16'hBBBB);
      eb = calc(hc, vc, x_pos[10:0], x_pos[21:11], my[0], my[1], 16'h1CE0);
      if (hc == 0 && vc == 600) begin
        for (int c = 0; c < 2; c++) begin
          if (up[c] && !dn[c]) my[c] = (my[c] - 4 < 0) ? 0 : my[c] - 4;
          else if (dn[c] && !up[c]) my[c] = (my[c] + 4 > 472) ? 472 : my[c] + 4;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("y0_a", int'(ifa.y_pos[9:0]), my[0]);
      check("y1_a", int'(ifa.y_pos[19:10]), my[1]);
      check("y0_b", int'(ifb.y_pos[9:0]), my[0]);
      check("y1_b", int'(ifb.y_pos[19:10]), my[1]);
      check("pixel_a", int'(ifa.pixel), ea);
      check("pixel_b", int'(ifb.pixel), eb);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic raster(input int h, input int v);
    hc = 11'(h); vc = 10'(v);
    cyc();
  endtask

  task automatic tick();
    raster(0, 600);
    raster(5, 5);
  endtask

  initial begin
    reset = 1'b1; up = '0; dn = '0; hc = 11'd5; vc = 10'd5;
    x_pos = {11'd1000, 11'd32};
    cyc(); cyc();
    chk_en = 1'b1;
    reset = 1'b0;

    // Idle ticks leave both paddles centred.
    repeat (3) tick();
    raster(500, 500);
    check("lit_idle_y0", int'(ifa.y_pos[9:0]), 236);
    check("lit_idle_y1", int'(ifa.y_pos[19:10]), 236);
    check("lit_idle_pix", int'(ifa.pixel), 0);

    // Edges of channel 0 at x=32, y=236.
    raster(32, 236);  check("lit_corner", int'(ifa.pixel), int'(RING_A));
    raster(48, 236);  check("lit_right_out", int'(ifa.pixel), 0);
    raster(31, 300);  check("lit_left_out", int'(ifa.pixel), 0);
    raster(47, 363);  check("lit_last", int'(ifa.pixel), int'(RING_A));
    raster(47, 364);  check("lit_below", int'(ifa.pixel), 0);
    raster(40, 300);  check("lit_inside", int'(ifa.pixel), 8'hBB);

    // Up to the top clamp, down to the bottom clamp, then both buttons.
    up = 2'b01;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (k == 0) check("lit_up_first", int'(ifa.y_pos[9:0]), 232);
    end
    check("lit_top_clamp", int'(ifa.y_pos[9:0]), 0);
    up = 2'b00; dn = 2'b01;
    repeat (120) tick();
    check("lit_bot_clamp", int'(ifa.y_pos[9:0]), 472);
    up = 2'b01;
    repeat (3) tick();
    check("lit_both_hold", int'(ifa.y_pos[9:0]), 472);

    // Button held, but only the exact tick point moves the paddle.
    dn = 2'b00;
    raster(0, 599);
    raster(1, 600);
    raster(0, 601);
    check("lit_off_tick", int'(ifa.y_pos[9:0]), 472);
    tick();
    check("lit_on_tick", int'(ifa.y_pos[9:0]), 468);
    up = 2'b00;

    // Overlapping paddles at (100,100): channel 0 wins.
    reset = 1'b1; cyc(); reset = 1'b0;
    x_pos = {11'd100, 11'd100};
    up = 2'b11;
    repeat (34) tick();
    up = 2'b00;
    check("lit_ovl_y1", int'(ifb.y_pos[19:10]), 100);
    raster(101, 101); check("lit_ovl_in_b", int'(ifb.pixel), 8'hE0);
    check("lit_ovl_in_a", int'(ifa.pixel), 8'hBB);
    raster(100, 100); check("lit_ovl_corner", int'(ifb.pixel), int'(RING_B));

    // Paddle near the right end of the raster: no wrap of the right edge.
    x_pos = {11'd2040, 11'd32};
    raster(2047, 150); check("lit_far_right", int'(ifb.pixel), 8'h1C);
    raster(2039, 150); check("lit_far_left_out", int'(ifb.pixel), 0);
    raster(5, 150);

    // Reset wins over a simultaneous tick and button.
    x_pos = {11'd1000, 11'd32};
    dn = 2'b11; reset = 1'b1;
    raster(0, 600);
    check("lit_rst_y0", int'(ifa.y_pos[9:0]), 236);
    check("lit_rst_y1", int'(ifa.y_pos[19:10]), 236);
    check("lit_rst_pix", int'(ifa.pixel), 0);
    reset = 1'b0; dn = 2'b00;
    raster(32, 236); check("lit_rst_corner", int'(ifa.pixel), int'(RING_A));
    raster(33, 237); check("lit_rst_inner", int'(ifa.pixel), 8'hBB);
    raster(5, 5);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
